fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 75 +++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: holds the PC, issues sequential reads to a 1-cycle instruction memory
// and buffers returned words in a small FIFO toward decode; redirects flush younger work.
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      instr_opcode
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [XLEN-1:0] buf_data [DEPTH];
    logic [XLEN-1:0] buf_pc   [DEPTH];
    logic            push;
    logic            pop;

    // the in-flight word already owns a buffer slot, so the FIFO cannot overflow
    assign imem_req     = !reset && !redirect_valid && (32'(count) + 32'(inflight) < DEPTH);
    assign imem_addr    = pc_q;
    assign push         = inflight && !redirect_valid;
    assign pop          = instr_valid && instr_ready && !redirect_valid;
    assign instr_valid  = count != '0;
    assign instr_data   = instr_valid ? buf_data[rd_ptr] : '0;
    assign instr_pc     = instr_valid ? buf_pc[rd_ptr] : '0;
    assign instr_opcode = instr_data[6:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            pc_q     <= redirect_pc & ~XLEN'(3);
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (imem_req) pc_q <= pc_q + XLEN'(4);
            inflight    <= imem_req;
            inflight_pc <= pc_q;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage with a 1-cycle memory returning addr ^ A5A5_0000.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0, req1;
    logic [31:0] addr0, addr1, rdata0, rdata1;
    logic        redirect = 1'b0;
    logic [31:0] rpc = '0;
    logic        valid0, valid1;
    logic        ready = 1'b1;
    logic        ready1 = 1'b1;
    logic        redirect1 = 1'b0;
    logic [31:0] rpc1 = '0;
    logic [31:0] data0, data1, ipc0, ipc1;
    logic [6:0]  op0, op1;

    int checks = 0;
    int errors = 0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_data;
    logic [6:0]  s_op;
    logic [31:0] iss[$], del[$], del_d[$], iss1[$], del1[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata0 <= addr0 ^ 32'hA5A5_0000;
        rdata1 <= addr1 ^ 32'hA5A5_0000;
    end

    fetch_stage u0 (
        .clk(clk), .reset(reset), .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
        .redirect_valid(redirect), .redirect_pc(rpc), .instr_valid(valid0), .instr_ready(ready),
        .instr_data(data0), .instr_pc(ipc0), .instr_opcode(op0)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .reset(reset), .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
        .redirect_valid(redirect1), .redirect_pc(rpc1), .instr_valid(valid1), .instr_ready(ready1),
        .instr_data(data1), .instr_pc(ipc1), .instr_opcode(op1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // one clock cycle: sample at negedge with the inputs already applied, then move past the posedge
    task automatic step();
        @(negedge clk);
        s_req = req0; s_addr = addr0; s_valid = valid0;
        s_pc = ipc0; s_data = data0; s_op = op0;
        if (req0) iss.push_back(addr0);
        if (valid0 && ready && !redirect) begin
            del.push_back(ipc0);
            del_d.push_back(data0);
        end
        if (req1) iss1.push_back(addr1);
        if (valid1) del1.push_back(ipc1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        iss.delete(); del.delete(); del_d.delete(); iss1.delete(); del1.delete();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_q();
    endtask

    initial begin
        logic found;
        @(posedge clk);
        #1;
        check("rst_req", 32'(req0), 0);
        check("rst_valid", 32'(valid0), 0);
        check("rst_addr", addr0, 32'h0);
        check("rst_data", data0, 32'h0);
        check("rst_pc", ipc0, 32'h0);
        check("rst_op", 32'(op0), 0);
        check("rst_addr_u1", addr1, 32'hFFFF_FFF8);
        // sequential fetch from reset
        reset = 1'b0;
        clear_q();
        step();
        check("t1_req0", 32'(s_req), 1);
        check("t1_addr0", s_addr, 32'h0);
        step();
        check("t1_valid_c1", 32'(s_valid), 0);
        step();
        check("t1_valid_c2", 32'(s_valid), 1);
        check("t1_pc_c2", s_pc, 32'h0);
        check("t1_data_c2", s_data, 32'hA5A5_0000);
        steps(12);
        for (int i = 0; i < 5; i++) begin
            check("t1_iss", iss[i], 32'(4 * i));
            check("t1_del_pc", del[i], 32'(4 * i));
            check("t1_del_data", del_d[i], 32'(4 * i) ^ 32'hA5A5_0000);
        end
        check("t1_op", 32'(s_op), 32'(s_data[6:0]));
        // back-pressure: exactly DEPTH requests then stall, head stable
        ready = 1'b0;
        do_reset();
        steps(6);
        check("t2_iss_n", 32'(iss.size()), 2);
        check("t2_iss0", iss[0], 32'h0);
        check("t2_iss1", iss[1], 32'h4);
        check("t2_req_stop", 32'(s_req), 0);
        check("t2_valid", 32'(s_valid), 1);
        check("t2_head_pc", s_pc, 32'h0);
        check("t2_head_op", 32'(s_op), 32'h0);
        ready = 1'b1;
        step();
        check("t2_pop_head", s_pc, 32'h0);
        step();
        check("t2_resume_req", 32'(s_req), 1);
        check("t2_resume_addr", s_addr, 32'h8);
        steps(6);
        check("t2_del0", del[0], 32'h0);
        check("t2_del1", del[1], 32'h4);
        check("t2_del2", del[2], 32'h8);
        // redirect with a buffered word and a word in flight; simultaneous pop loses
        ready = 1'b0;
        do_reset();
        steps(2);
        ready = 1'b1;
        redirect = 1'b1;
        rpc = 32'h0000_0103;
        step();
        check("t3_req_redir", 32'(s_req), 0);
        redirect = 1'b0;
        clear_q();
        step();
        check("t3_valid_flush", 32'(s_valid), 0);
        check("t3_req", 32'(s_req), 1);
        check("t3_addr", s_addr, 32'h0000_0100);
        steps(6);
        check("t3_del_pc", del[0], 32'h0000_0100);
        check("t3_del_data", del_d[0], 32'hA5A5_0100);
        check("t3_del_pc1", del[1], 32'h0000_0104);
        // back-to-back redirects: last target wins
        redirect = 1'b1;
        rpc = 32'h200;
        step();
        check("t4_req_a", 32'(s_req), 0);
        rpc = 32'h300;
        step();
        check("t4_req_b", 32'(s_req), 0);
        redirect = 1'b0;
        clear_q();
        step();
        check("t4_req", 32'(s_req), 1);
        check("t4_addr", s_addr, 32'h300);
        steps(6);
        found = 1'b0;
        foreach (iss[i]) if (iss[i] == 32'h200) found = 1'b1;
        check("t4_no_200", 32'(found), 0);
        check("t4_del0", del[0], 32'h300);
        // PC wrap on the second instance
        do_reset();
        steps(10);
        check("t5_iss0", iss1[0], 32'hFFFF_FFF8);
        check("t5_iss1", iss1[1], 32'hFFFF_FFFC);
        check("t5_iss2", iss1[2], 32'h0000_0000);
        check("t5_del0", del1[0], 32'hFFFF_FFF8);
        check("t5_del1", del1[1], 32'hFFFF_FFFC);
        check("t5_del2", del1[2], 32'h0000_0000);
        // asynchronous reset with a buffered word and one in flight
        ready = 1'b0;
        do_reset();
        steps(2);
        check("t6_pre_valid", 32'(valid0), 1);
        reset = 1'b1;
        #1;
        check("t6_valid_drop", 32'(valid0), 0);
        check("t6_req_drop", 32'(req0), 0);
        step();
        reset = 1'b0;
        ready = 1'b1;
        clear_q();
        step();
        check("t6_req", 32'(s_req), 1);
        check("t6_addr", s_addr, 32'h0);
        step();
        check("t6_no_stale", 32'(s_valid), 0);
        step();
        check("t6_first_pc", s_pc, 32'h0);
        check("t6_first_data", s_data, 32'hA5A5_0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
